fp7_alu_issue_scheduler: RTL and testbench
==========================================

Name: fp7_alu_issue_scheduler

Overview:
- Shares one fixed-latency, non-stallable fp7 ALU add pipeline (compare → alignment → add → normalize) between NUM_REQ requesters.
- Round-robin arbitration on valid/ready request ports; registered issue of operands into pipeline stage 0.
- Tracks each in-flight op's requester ID through a tag shift register matching pipeline latency; captures results into a response FIFO.
- Credit check guarantees a slot for every in-flight result, since the pipeline cannot stall.

Parameters:
- NUM_REQ, 2, number of requesters (≥2)
- EXPONENT_WIDTH, 8, operand exponent width
- MANTISSA_WIDTH, 24, operand mantissa width; OP_WIDTH = 1+EXPONENT_WIDTH+MANTISSA_WIDTH (localparam)
- PIPE_LATENCY, 4, cycles from o_issue_valid to matching i_pipe_result (≥1)
- FIFO_DEPTH, 8, response FIFO entries (power of 2, ≥ PIPE_LATENCY)
- ID_WIDTH (localparam), clog2(NUM_REQ), min 1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_req_valid  in  NUM_REQ  per-requester request valid
- o_req_ready  out  NUM_REQ  per-requester accept (combinational)
- i_req_a  in  NUM_REQ*OP_WIDTH  operand A, requester k at [k*OP_WIDTH +: OP_WIDTH]
- i_req_b  in  NUM_REQ*OP_WIDTH  operand B, same packing
- o_issue_valid  out  1  operands valid into pipeline stage 0
- o_issue_a, o_issue_b  out  OP_WIDTH  issued operands
- i_pipe_result  in  OP_WIDTH  pipeline output; sampled only when the tag is due
- o_rsp_valid  out  1  FIFO non-empty
- i_rsp_ready  in  1  consumer accept
- o_rsp_id  out  ID_WIDTH  requester of head result
- o_rsp_data  out  OP_WIDTH  head result
- o_inflight  out  clog2(FIFO_DEPTH)+1  ops issued but not yet in FIFO

Behaviour:
- Reset values: o_issue_valid=0, o_issue_a/b=0, o_rsp_valid=0, o_inflight=0, o_req_ready=0. RR pointer=0, tag register cleared, FIFO empty.
- Reset mid-operation: all in-flight tags and FIFO contents are discarded. Pipeline outputs arriving after reset release are ignored because no tag is due.
- Credit:
  - credit = FIFO_DEPTH − fifo_count − inflight, where inflight counts valid tag bits including the issue register.
  - A pop in the same cycle does not add credit (conservative; no comb path from i_rsp_ready to o_req_ready).
- Arbitration:
  - grant = first k with i_req_valid[k], searching ptr, ptr+1, … mod NUM_REQ.
  - o_req_ready[k] = grant[k] & (credit>0). At most one ready bit is high per cycle.
  - o_req_ready may depend on i_req_valid, but valid must not depend on ready.
- Handshake:
  - Accept = i_req_valid[g] & o_req_ready[g].
  - On accept: next cycle o_issue_valid=1, o_issue_a/b = requester g's operands, tag[0] = {1,g}; ptr ← (g+1) mod NUM_REQ.
  - No accept: o_issue_valid=0; ptr unchanged; o_issue_a/b hold their previous value.
- Tag pipeline:
  - PIPE_LATENCY-deep shift register of {valid,id}, entered in the same cycle o_issue_valid is asserted.
  - When the valid bit exits (PIPE_LATENCY cycles after o_issue_valid), push {id, i_pipe_result} into the FIFO that edge.
  - inflight decrements on push and increments on accept; both in one cycle leave it unchanged.
- FIFO:
  - First-word fall-through; o_rsp_valid = !empty; pop on o_rsp_valid & i_rsp_ready.
  - Simultaneous push and pop is legal at any occupancy, including full (credit forbids overflow) and empty (the pushed entry appears the next cycle).
  - Wrap-around via log2 pointers plus count register.
- Overflow is impossible by construction. Verification asserts: push while full never occurs; inflight+fifo_count ≤ FIFO_DEPTH.
- Throughput: one issue per cycle while credit is available. A single continuously valid requester issues every cycle.
- Result order equals issue order.

Decomposition:
- Shared header fp7_alu_defs.vh:
  - clog2 function
  - OP_WIDTH derivation
  - default EXPONENT_WIDTH/MANTISSA_WIDTH
  - PIPE_LATENCY constant of the add pipeline, so scheduler and datapath agree
- Sub-module fp7_alu_rsp_fifo: parameterised sync FWFT FIFO (width ID_WIDTH+OP_WIDTH, depth FIFO_DEPTH, async active-high rst), exposing count.
- Arbiter, credit logic and tag shift register stay inline.

Test Plan:
- Single op: req0 valid with A=0x3F800000, B=0x40000000; model pipe returns 0x40400000 → o_issue_valid 1 cycle after accept; rsp (id=0, 0x40400000) valid at cycle 1+PIPE_LATENCY+1; o_inflight returns to 0.
- Both requesters continuously valid, NUM_REQ=2, i_rsp_ready=1 → grants alternate 0,1,0,1; o_issue_valid high every cycle; o_rsp_id sequence 0,1,0,1 in order.
- Backpressure: i_rsp_ready=0, req0 always valid → exactly FIFO_DEPTH=8 accepts; o_req_ready stays 0 thereafter. Raise i_rsp_ready → 8 results drain in order, then issue resumes, no loss or duplication.
- Full-boundary simultaneous push/pop: FIFO at 7, one in flight, i_rsp_ready=1 → push and pop on the same edge; count stays 7; data intact.
- Reset mid-operation: assert rst with 3 in flight and 2 in FIFO → outputs go to reset values immediately (async). After release, o_rsp_valid stays 0 despite pipeline output activity; the next request completes normally with id correct.
- Fairness with gaps: req1 valid only on odd cycles, req0 always valid → req1 is served within 2 cycles of each assertion; the pointer never starves either requester.

Source files
------------

// File: rtl/fp7_alu_issue_scheduler_pkg.sv
// Shared constants and elaboration helpers for the fp7 ALU issue scheduler and its add datapath.
package fp7_alu_issue_scheduler_pkg;

    localparam int DEF_EXPONENT_WIDTH = 8;
    localparam int DEF_MANTISSA_WIDTH = 24;
    // Latency of the compare/align/add/normalize pipeline; scheduler and datapath both use it.
    localparam int ADD_PIPE_LATENCY   = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    function automatic int op_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int id_width(input int num_req);
        return (clog2(num_req) < 1) ? 1 : clog2(num_req);
    endfunction

endpackage

// File: rtl/fp7_alu_rsp_fifo.sv
// First-word fall-through response FIFO with occupancy count; push while full is legal only with a pop.
module fp7_alu_rsp_fifo
    import fp7_alu_issue_scheduler_pkg::*;
#(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8,
    localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int CW = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign pop_ok_s  = i_pop && (count_q != {CW{1'b0}});
    assign push_ok_s = i_push && ((count_q != CW'(DEPTH)) || pop_ok_s);
    assign o_empty   = (count_q == {CW{1'b0}});
    assign o_head    = mem_q[rd_ptr_q];
    assign o_count   = count_q;

    // Pointer and count next-state; depth is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

endmodule

// File: rtl/fp7_alu_issue_scheduler.sv
// Round-robin, credit-gated issue of requester operands into a fixed-latency fp7 add pipeline,
// with requester tags tracked alongside the pipeline and results collected in order.
module fp7_alu_issue_scheduler
    import fp7_alu_issue_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int EXPONENT_WIDTH = DEF_EXPONENT_WIDTH,
    parameter int MANTISSA_WIDTH = DEF_MANTISSA_WIDTH,
    parameter int PIPE_LATENCY   = ADD_PIPE_LATENCY,
    parameter int FIFO_DEPTH     = 8,
    localparam int OP_WIDTH  = op_width(EXPONENT_WIDTH, MANTISSA_WIDTH),
    localparam int ID_WIDTH  = id_width(NUM_REQ),
    localparam int CNT_WIDTH = clog2(FIFO_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    output logic [NUM_REQ-1:0]          o_req_ready,
    input  logic [NUM_REQ*OP_WIDTH-1:0] i_req_a,
    input  logic [NUM_REQ*OP_WIDTH-1:0] i_req_b,
    output logic                        o_issue_valid,
    output logic [OP_WIDTH-1:0]         o_issue_a,
    output logic [OP_WIDTH-1:0]         o_issue_b,
    input  logic [OP_WIDTH-1:0]         i_pipe_result,
    output logic                        o_rsp_valid,
    input  logic                        i_rsp_ready,
    output logic [ID_WIDTH-1:0]         o_rsp_id,
    output logic [OP_WIDTH-1:0]         o_rsp_data,
    output logic [CNT_WIDTH-1:0]        o_inflight
);

    logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
    logic                 issue_valid_q, issue_valid_d;
    logic [OP_WIDTH-1:0]  issue_a_q, issue_a_d;
    logic [OP_WIDTH-1:0]  issue_b_q, issue_b_d;
    // Index 0 lines up with the issue register; the last index marks a result due this cycle.
    logic                 tag_vld_q [0:PIPE_LATENCY];
    logic                 tag_vld_d [0:PIPE_LATENCY];
    logic [ID_WIDTH-1:0]  tag_id_q  [0:PIPE_LATENCY];
    logic [ID_WIDTH-1:0]  tag_id_d  [0:PIPE_LATENCY];
    logic [CNT_WIDTH-1:0] inflight_q, inflight_d;

    logic                 grant_found_s;
    logic [ID_WIDTH-1:0]  grant_idx_s;
    logic [ID_WIDTH-1:0]  cand_s;
    logic [OP_WIDTH-1:0]  sel_a_s;
    logic [OP_WIDTH-1:0]  sel_b_s;
    logic [CNT_WIDTH:0]   occupancy_s;
    logic                 credit_ok_s;
    logic                 accept_s;
    logic                 push_s;
    logic                 pop_s;
    logic [CNT_WIDTH-1:0] fifo_count_s;
    logic                 fifo_empty_s;
    logic [ID_WIDTH+OP_WIDTH-1:0] fifo_head_s;

    // Credit ignores a same-cycle pop so that ready never depends on i_rsp_ready.
    assign occupancy_s = {1'b0, fifo_count_s} + {1'b0, inflight_q};
    assign credit_ok_s = (occupancy_s < (CNT_WIDTH+1)'(FIFO_DEPTH));
    assign accept_s    = grant_found_s && credit_ok_s && !rst;
    assign push_s      = tag_vld_q[PIPE_LATENCY];
    assign pop_s       = !fifo_empty_s && i_rsp_ready;

    // Round-robin search starting at the pointer, plus operand selection for the winner.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {ID_WIDTH{1'b0}};
        cand_s        = {ID_WIDTH{1'b0}};
        sel_a_s       = {OP_WIDTH{1'b0}};
        sel_b_s       = {OP_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = ID_WIDTH'((int'(ptr_q) + i) % NUM_REQ);
            if (!grant_found_s && i_req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx_s == ID_WIDTH'(k)) begin
                sel_a_s = i_req_a[k*OP_WIDTH +: OP_WIDTH];
                sel_b_s = i_req_b[k*OP_WIDTH +: OP_WIDTH];
            end else begin
                sel_a_s = sel_a_s;
            end
        end
    end

    // One-hot ready toward the granted requester only.
    always_comb begin
        o_req_ready = {NUM_REQ{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (accept_s && (grant_idx_s == ID_WIDTH'(k))) begin
                o_req_ready[k] = 1'b1;
            end else begin
                o_req_ready[k] = 1'b0;
            end
        end
    end

    // Issue register, pointer, tag shift and in-flight count next-state.
    always_comb begin
        ptr_d         = ptr_q;
        issue_valid_d = accept_s;
        issue_a_d     = issue_a_q;
        issue_b_d     = issue_b_q;
        inflight_d    = inflight_q;
        if (accept_s) begin
            issue_a_d = sel_a_s;
            issue_b_d = sel_b_s;
            if (grant_idx_s == ID_WIDTH'(NUM_REQ - 1)) begin
                ptr_d = {ID_WIDTH{1'b0}};
            end else begin
                ptr_d = grant_idx_s + ID_WIDTH'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
        tag_vld_d[0] = accept_s;
        tag_id_d[0]  = grant_idx_s;
        for (int k = 1; k <= PIPE_LATENCY; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end
        case ({accept_s, push_s})
            2'b10:   inflight_d = inflight_q + CNT_WIDTH'(1);
            2'b01:   inflight_d = inflight_q - CNT_WIDTH'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Scheduler state registers; reset drops every in-flight tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q         <= {ID_WIDTH{1'b0}};
            issue_valid_q <= 1'b0;
            issue_a_q     <= {OP_WIDTH{1'b0}};
            issue_b_q     <= {OP_WIDTH{1'b0}};
            inflight_q    <= {CNT_WIDTH{1'b0}};
            for (int k = 0; k <= PIPE_LATENCY; k++) begin
                tag_vld_q[k] <= 1'b0;
                tag_id_q[k]  <= {ID_WIDTH{1'b0}};
            end
        end else begin
            ptr_q         <= ptr_d;
            issue_valid_q <= issue_valid_d;
            issue_a_q     <= issue_a_d;
            issue_b_q     <= issue_b_d;
            inflight_q    <= inflight_d;
            for (int k = 0; k <= PIPE_LATENCY; k++) begin
                tag_vld_q[k] <= tag_vld_d[k];
                tag_id_q[k]  <= tag_id_d[k];
            end
        end
    end

    fp7_alu_rsp_fifo #(
        .WIDTH (ID_WIDTH + OP_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (push_s),
        .i_push_data ({tag_id_q[PIPE_LATENCY], i_pipe_result}),
        .i_pop       (pop_s),
        .o_empty     (fifo_empty_s),
        .o_head      (fifo_head_s),
        .o_count     (fifo_count_s)
    );

    assign o_issue_valid = issue_valid_q;
    assign o_issue_a     = issue_a_q;
    assign o_issue_b     = issue_b_q;
    assign o_rsp_valid   = !fifo_empty_s;
    assign o_rsp_id      = fifo_head_s[ID_WIDTH+OP_WIDTH-1 -: ID_WIDTH];
    assign o_rsp_data    = fifo_head_s[OP_WIDTH-1:0];
    assign o_inflight    = inflight_q;

endmodule

// File: tb/tb_fp7_alu_issue_scheduler.sv
// Directed bench for fp7_alu_issue_scheduler with a delay-line model of the add pipeline.
module tb_fp7_alu_issue_scheduler;

    localparam int OPW = 33;
    localparam int LAT = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       i_req_valid;
    logic [1:0]       o_req_ready;
    logic [2*OPW-1:0] i_req_a;
    logic [2*OPW-1:0] i_req_b;
    logic             o_issue_valid;
    logic [OPW-1:0]   o_issue_a;
    logic [OPW-1:0]   o_issue_b;
    logic [OPW-1:0]   i_pipe_result;
    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic [0:0]       o_rsp_id;
    logic [OPW-1:0]   o_rsp_data;
    logic [3:0]       o_inflight;

    int total = 0;
    int bad   = 0;

    fp7_alu_issue_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_a       (i_req_a),
        .i_req_b       (i_req_b),
        .o_issue_valid (o_issue_valid),
        .o_issue_a     (o_issue_a),
        .o_issue_b     (o_issue_b),
        .i_pipe_result (i_pipe_result),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_id      (o_rsp_id),
        .o_rsp_data    (o_rsp_data),
        .o_inflight    (o_inflight)
    );

    always #5 clk = ~clk;

    // Stand-in adder: one known fp32 sum, XOR of operands otherwise.
    function automatic logic [OPW-1:0] pipe_fn(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        if (a == 33'h0_3F80_0000 && b == 33'h0_4000_0000) return 33'h0_4040_0000;
        return a ^ b;
    endfunction

    logic [OPW-1:0] pipe_q [0:LAT-1];
    always @(posedge clk) begin
        pipe_q[0] <= o_issue_valid ? pipe_fn(o_issue_a, o_issue_b) : 33'h1_DEAD_BEEF;
        for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
    assign i_pipe_result = pipe_q[LAT-1];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_req_valid = 2'b11;
        i_req_a = {33'h0_0000_0AAA, 33'h0_0000_0555};
        i_req_b = {33'h0_0000_0001, 33'h0_0000_0002};
        @(negedge clk);
        total++; if (o_issue_valid !== 1'b0) begin bad++; $display("FAIL reset_issue_valid got=%b exp=0", o_issue_valid); end
        total++; if (o_issue_a !== 33'h0) begin bad++; $display("FAIL reset_issue_a got=%h exp=0", o_issue_a); end
        total++; if (o_issue_b !== 33'h0) begin bad++; $display("FAIL reset_issue_b got=%h exp=0", o_issue_b); end
        total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", o_rsp_valid); end
        total++; if (o_inflight !== 4'd0) begin bad++; $display("FAIL reset_inflight got=%0d exp=0", o_inflight); end
        total++; if (o_req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b exp=00", o_req_ready); end
        next_cycle();
        rst = 1'b0;
        i_req_valid = 2'b00;
        next_cycle();
    endtask

    task automatic test_single_op();
        i_req_valid = 2'b01;
        i_req_a = {33'h0, 33'h0_3F80_0000};
        i_req_b = {33'h0, 33'h0_4000_0000};
        @(negedge clk);
        total++; if (o_req_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b exp=01", o_req_ready); end
        next_cycle();
        i_req_valid = 2'b00;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            total++; if (o_issue_valid !== (c == 1)) begin bad++; $display("FAIL single_issue_valid c=%0d got=%b", c, o_issue_valid); end
            total++; if (o_rsp_valid !== (c == 6)) begin bad++; $display("FAIL single_rsp_valid c=%0d got=%b", c, o_rsp_valid); end
            total++; if (o_inflight !== ((c <= 5) ? 4'd1 : 4'd0)) begin bad++; $display("FAIL single_inflight c=%0d got=%0d", c, o_inflight); end
            if (c <= 2) begin
                total++; if (o_issue_a !== 33'h0_3F80_0000) begin bad++; $display("FAIL single_issue_a c=%0d got=%h exp=3f800000", c, o_issue_a); end
                total++; if (o_issue_b !== 33'h0_4000_0000) begin bad++; $display("FAIL single_issue_b c=%0d got=%h exp=40000000", c, o_issue_b); end
            end
            if (c == 6) begin
                total++; if (o_rsp_id !== 1'b0) begin bad++; $display("FAIL single_rsp_id got=%0d exp=0", o_rsp_id); end
                total++; if (o_rsp_data !== 33'h0_4040_0000) begin bad++; $display("FAIL single_rsp_data got=%h exp=40400000", o_rsp_data); end
            end
            next_cycle();
        end
        i_rsp_ready = 1'b1;
        next_cycle();
        i_rsp_ready = 1'b0;
        @(negedge clk);
        total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL single_after_pop got=%b exp=0", o_rsp_valid); end
        next_cycle();
    endtask

    // Pointer is 1 here (last grant went to requester 0), so grants run 1,0,1,0...
    task automatic test_back_to_back();
        int got = 0;
        logic [0:0] exp_id;
        i_rsp_ready = 1'b1;
        i_req_a = {33'h0_0000_0200, 33'h0_0000_0100};
        i_req_b = {33'h0_0000_0002, 33'h0_0000_0001};
        for (int c = 0; c < 20; c++) begin
            i_req_valid = (c < 8) ? 2'b11 : 2'b00;
            @(negedge clk);
            if (c < 8) begin
                total++; if (o_req_ready !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL b2b_ready c=%0d got=%b", c, o_req_ready); end
            end
            if (c >= 1 && c <= 8) begin
                total++; if (o_issue_valid !== 1'b1) begin bad++; $display("FAIL b2b_issue_valid c=%0d got=%b exp=1", c, o_issue_valid); end
            end
            if (o_rsp_valid) begin
                exp_id = (got % 2 == 0) ? 1'b1 : 1'b0;
                total++; if (o_rsp_id !== exp_id) begin bad++; $display("FAIL b2b_rsp_id n=%0d got=%0d exp=%0d", got, o_rsp_id, exp_id); end
                total++; if (o_rsp_data !== (exp_id ? 33'h0_0000_0202 : 33'h0_0000_0101)) begin bad++; $display("FAIL b2b_rsp_data n=%0d got=%h", got, o_rsp_data); end
                got++;
            end
            next_cycle();
        end
        total++; if (got !== 8) begin bad++; $display("FAIL b2b_rsp_count got=%0d exp=8", got); end
    endtask

    task automatic test_backpressure();
        int got = 0;
        logic found = 1'b0;
        i_rsp_ready = 1'b0;
        i_req_b = {2*OPW{1'b0}};
        for (int c = 0; c < 16; c++) begin
            i_req_valid = 2'b01;
            i_req_a = {33'h0, OPW'(32'h1000 + c)};
            @(negedge clk);
            total++; if (o_req_ready !== ((c < 8) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL bp_ready c=%0d got=%b", c, o_req_ready); end
            next_cycle();
        end
        @(negedge clk);
        total++; if (o_inflight !== 4'd0) begin bad++; $display("FAIL bp_inflight got=%0d exp=0", o_inflight); end
        next_cycle();
        i_req_valid = 2'b00;
        i_rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (o_rsp_valid) begin
                total++; if (o_rsp_id !== 1'b0) begin bad++; $display("FAIL bp_rsp_id n=%0d got=%0d exp=0", got, o_rsp_id); end
                total++; if (o_rsp_data !== OPW'(32'h1000 + got)) begin bad++; $display("FAIL bp_rsp_data n=%0d got=%h exp=%h", got, o_rsp_data, 32'h1000 + got); end
                got++;
            end
            next_cycle();
        end
        total++; if (got !== 8) begin bad++; $display("FAIL bp_drain_count got=%0d exp=8", got); end
        i_req_valid = 2'b01;
        i_req_a = {33'h0, 33'h0_0000_1100};
        @(negedge clk);
        total++; if (o_req_ready !== 2'b01) begin bad++; $display("FAIL bp_resume_ready got=%b exp=01", o_req_ready); end
        next_cycle();
        i_req_valid = 2'b00;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_rsp_valid && !found) begin
                found = 1'b1;
                total++; if (o_rsp_data !== 33'h0_0000_1100) begin bad++; $display("FAIL bp_resume_data got=%h exp=1100", o_rsp_data); end
            end
            next_cycle();
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL bp_resume_timeout got=%b exp=1", found); end
    endtask

    task automatic test_full_boundary();
        int got = 0;
        i_rsp_ready = 1'b0;
        i_req_b = {2*OPW{1'b0}};
        for (int c = 0; c < 16; c++) begin
            i_req_valid = 2'b01;
            i_req_a = {33'h0, OPW'(32'h2000 + ((c < 8) ? c : 7))};
            next_cycle();
        end
        i_req_valid = 2'b00;
        i_rsp_ready = 1'b1;
        @(negedge clk);
        total++; if (o_rsp_data !== 33'h0_0000_2000) begin bad++; $display("FAIL fb_first_pop got=%h exp=2000", o_rsp_data); end
        next_cycle();
        i_rsp_ready = 1'b0;
        i_req_valid = 2'b01;
        i_req_a = {33'h0, 33'h0_0000_2008};
        @(negedge clk);
        total++; if (o_req_ready !== 2'b01) begin bad++; $display("FAIL fb_seven_ready got=%b exp=01", o_req_ready); end
        next_cycle();
        i_req_a = {33'h0, 33'h0_0000_2FFF};
        for (int c = 1; c <= 5; c++) begin
            i_rsp_ready = (c == 5);
            @(negedge clk);
            total++; if (o_req_ready !== 2'b00) begin bad++; $display("FAIL fb_no_credit c=%0d got=%b exp=00", c, o_req_ready); end
            total++; if (o_inflight !== 4'd1) begin bad++; $display("FAIL fb_inflight c=%0d got=%0d exp=1", c, o_inflight); end
            next_cycle();
        end
        i_req_valid = 2'b00;
        i_rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin
                total++; if (o_inflight !== 4'd0) begin bad++; $display("FAIL fb_inflight_after got=%0d exp=0", o_inflight); end
            end
            if (o_rsp_valid) begin
                total++; if (o_rsp_data !== OPW'(32'h2002 + got)) begin bad++; $display("FAIL fb_drain_data n=%0d got=%h exp=%h", got, o_rsp_data, 32'h2002 + got); end
                got++;
            end
            next_cycle();
        end
        total++; if (got !== 7) begin bad++; $display("FAIL fb_drain_count got=%0d exp=7", got); end
    endtask

    task automatic test_reset_mid();
        logic found = 1'b0;
        i_rsp_ready = 1'b0;
        i_req_b = {2*OPW{1'b0}};
        for (int c = 0; c < 5; c++) begin
            i_req_valid = 2'b01;
            i_req_a = {33'h0, OPW'(32'h3000 + c)};
            next_cycle();
        end
        i_req_valid = 2'b00;
        next_cycle();
        next_cycle();
        @(negedge clk);
        total++; if (o_inflight !== 4'd3) begin bad++; $display("FAIL rm_pre_inflight got=%0d exp=3", o_inflight); end
        total++; if (o_rsp_valid !== 1'b1) begin bad++; $display("FAIL rm_pre_rsp_valid got=%b exp=1", o_rsp_valid); end
        #2;
        i_req_valid = 2'b01;
        rst = 1'b1;
        #1;
        total++; if (o_inflight !== 4'd0) begin bad++; $display("FAIL rm_inflight got=%0d exp=0", o_inflight); end
        total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL rm_rsp_valid got=%b exp=0", o_rsp_valid); end
        total++; if (o_issue_a !== 33'h0) begin bad++; $display("FAIL rm_issue_a got=%h exp=0", o_issue_a); end
        total++; if (o_req_ready !== 2'b00) begin bad++; $display("FAIL rm_req_ready got=%b exp=00", o_req_ready); end
        next_cycle();
        rst = 1'b0;
        i_req_valid = 2'b00;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL rm_stale_rsp c=%0d got=%b exp=0", c, o_rsp_valid); end
            next_cycle();
        end
        i_rsp_ready = 1'b1;
        i_req_valid = 2'b10;
        i_req_a = {33'h0_0000_4444, 33'h0};
        i_req_b = {33'h0_0000_0011, 33'h0};
        @(negedge clk);
        total++; if (o_req_ready !== 2'b10) begin bad++; $display("FAIL rm_next_ready got=%b exp=10", o_req_ready); end
        next_cycle();
        i_req_valid = 2'b00;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_rsp_valid && !found) begin
                found = 1'b1;
                total++; if (o_rsp_id !== 1'b1) begin bad++; $display("FAIL rm_next_id got=%0d exp=1", o_rsp_id); end
                total++; if (o_rsp_data !== 33'h0_0000_4455) begin bad++; $display("FAIL rm_next_data got=%h exp=4455", o_rsp_data); end
            end
            next_cycle();
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL rm_next_timeout got=%b exp=1", found); end
    endtask

    // Pointer is 0 after the lone requester-1 grant; req1 appears on odd cycles and wins those.
    task automatic test_fairness();
        int got = 0;
        logic [0:0] exp_id;
        i_rsp_ready = 1'b1;
        i_req_a = {33'h0_0000_0500, 33'h0_0000_0050};
        i_req_b = {33'h0_0000_0005, 33'h0};
        for (int c = 0; c < 24; c++) begin
            i_req_valid = (c < 12) ? ((c % 2 == 1) ? 2'b11 : 2'b01) : 2'b00;
            @(negedge clk);
            if (c < 12) begin
                total++; if (o_req_ready !== ((c % 2 == 1) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL fair_ready c=%0d got=%b", c, o_req_ready); end
            end
            if (o_rsp_valid) begin
                exp_id = (got % 2 == 1) ? 1'b1 : 1'b0;
                total++; if (o_rsp_id !== exp_id) begin bad++; $display("FAIL fair_rsp_id n=%0d got=%0d exp=%0d", got, o_rsp_id, exp_id); end
                total++; if (o_rsp_data !== (exp_id ? 33'h0_0000_0505 : 33'h0_0000_0050)) begin bad++; $display("FAIL fair_rsp_data n=%0d got=%h", got, o_rsp_data); end
                got++;
            end
            next_cycle();
        end
        total++; if (got !== 12) begin bad++; $display("FAIL fair_rsp_count got=%0d exp=12", got); end
    endtask

    initial begin
        rst         = 1'b1;
        i_req_valid = 2'b00;
        i_req_a     = {2*OPW{1'b0}};
        i_req_b     = {2*OPW{1'b0}};
        i_rsp_ready = 1'b0;
        test_reset();
        test_single_op();
        test_back_to_back();
        test_backpressure();
        test_full_boundary();
        test_reset_mid();
        test_fairness();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
